// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot_pkg
// Brief    : Shared types and elaboration helpers for pipelined_dot_product.
// Revision : 1.0 - initial release
// ============================================================================
package dot_pkg;

    localparam int DOT_N_DEFAULT     = 4;
    localparam int DOT_W_DEFAULT     = 8;
    localparam int DOT_OUT_W_DEFAULT = 32;
    localparam int DOT_CNT_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        DOT_IDLE  = 1'b0,
        DOT_ACCUM = 1'b1
    } dot_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int tree_depth(input int leaves);
        return clog2(leaves);
    endfunction

    function automatic int level_width(input int leaf_w, input int level);
        return leaf_w + level;
    endfunction

    function automatic int level_nodes(input int leaves, input int level);
        return (leaves + (1 << level) - 1) >> level;
    endfunction

    // Bit offset of a tree level inside the flattened all-levels bus.
    function automatic int level_offset(input int leaves, input int leaf_w, input int level);
        int off;
        off = 0;
        for (int j = 0; j < level; j++) begin
            off += level_nodes(leaves, j) * level_width(leaf_w, j);
        end
        return off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_dot_product_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_dot_product_if
// Brief    : Beat input / frame result bundle for pipelined_dot_product.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_dot_product_if
    import dot_pkg::*;
#(
    parameter int N     = DOT_N_DEFAULT,
    parameter int W     = DOT_W_DEFAULT,
    parameter int OUT_W = DOT_OUT_W_DEFAULT,
    parameter int CNT_W = DOT_CNT_W_DEFAULT
) ();

    logic             in_valid;
    logic             in_last;
    logic [N*W-1:0]   a_vec;
    logic [N*W-1:0]   b_vec;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in_last, a_vec, b_vec,
        input  out_valid, out_data, out_beats
    );

    modport slave (
        input  in_valid, in_last, a_vec, b_vec,
        output out_valid, out_data, out_beats
    );

endinterface
`default_nettype wire

// File: rtl/dot_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : dot_adder_tree
// Brief    : Registered binary reduction tree, one level per cycle, valid/last
//            carried alongside; LEAVES=1 degenerates to a wire.
// Revision : 1.0 - initial release
// ============================================================================
module dot_adder_tree
    import dot_pkg::*;
#(
    parameter int LEAVES = 4,
    parameter int LEAF_W = 16,
    localparam int DEPTH = tree_depth(LEAVES),
    localparam int SUM_W = LEAF_W + DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [LEAVES*LEAF_W-1:0] in_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [SUM_W-1:0]         out_data
);

    localparam int TOTAL_W = level_offset(LEAVES, LEAF_W, DEPTH + 1);

    // Every level (inputs at level 0) packed side by side, widening by one bit per level.
    wire [TOTAL_W-1:0] w_level;
    wire [DEPTH:0]     w_valid;
    wire [DEPTH:0]     w_last;

    assign w_level[LEAVES*LEAF_W-1:0] = in_data;
    assign w_valid[0]                 = in_valid;
    assign w_last[0]                  = in_last;

    generate
        for (genvar k = 1; k <= DEPTH; k++) begin : g_level
            localparam int NODES = level_nodes(LEAVES, k);
            localparam int PREV  = level_nodes(LEAVES, k - 1);
            localparam int LW    = level_width(LEAF_W, k);
            localparam int PW    = level_width(LEAF_W, k - 1);
            localparam int OFF   = level_offset(LEAVES, LEAF_W, k);
            localparam int POFF  = level_offset(LEAVES, LEAF_W, k - 1);

            logic r_valid;
            logic r_last;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_valid[k-1];
                end
            end

            always_ff @(posedge clk) begin
                r_last <= w_last[k-1];
            end

            assign w_valid[k] = r_valid;
            assign w_last[k]  = r_last;

            for (genvar j = 0; j < NODES; j++) begin : g_node
                logic [LW-1:0] r_node;

                if (2 * j + 1 < PREV) begin : g_add
                    always_ff @(posedge clk) begin
                        r_node <= {1'b0, w_level[POFF + 2*j*PW +: PW]}
                                + {1'b0, w_level[POFF + (2*j+1)*PW +: PW]};
                    end
                end else begin : g_pass
                    always_ff @(posedge clk) begin
                        r_node <= {1'b0, w_level[POFF + 2*j*PW +: PW]};
                    end
                end

                assign w_level[OFF + j*LW +: LW] = r_node;
            end
        end
    endgenerate

    assign out_valid = w_valid[DEPTH];
    assign out_last  = w_last[DEPTH];
    assign out_data  = w_level[level_offset(LEAVES, LEAF_W, DEPTH) +: SUM_W];

endmodule
`default_nettype wire

// File: rtl/pipelined_dot_product.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_dot_product
// Brief    : Streaming N-element inner product accumulated per frame.
//            Build option DOT_SATURATE_EN: clamp the frame sum instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_dot_product
    import dot_pkg::*;
#(
    parameter int N     = DOT_N_DEFAULT,
    parameter int W     = DOT_W_DEFAULT,
    parameter int OUT_W = DOT_OUT_W_DEFAULT,
    parameter int CNT_W = DOT_CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_dot_product_if.slave bus
);

    localparam int PROD_W = 2 * W;
    localparam int TREE_W = PROD_W + tree_depth(N);

    logic [N*PROD_W-1:0] r_prod;
    logic                r_prod_valid;
    logic                r_prod_last;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            r_prod[i*PROD_W +: PROD_W] <= PROD_W'(bus.a_vec[i*W +: W]) * PROD_W'(bus.b_vec[i*W +: W]);
        end
        r_prod_last <= bus.in_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod_valid <= 1'b0;
        end else begin
            r_prod_valid <= bus.in_valid;
        end
    end

    logic              w_tree_valid;
    logic              w_tree_last;
    logic [TREE_W-1:0] w_tree_data;

    dot_adder_tree #(
        .LEAVES (N),
        .LEAF_W (PROD_W)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_prod_valid),
        .in_last   (r_prod_last),
        .in_data   (r_prod),
        .out_valid (w_tree_valid),
        .out_last  (w_tree_last),
        .out_data  (w_tree_data)
    );

    dot_state_t       r_state;
    dot_state_t       w_state_next;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_acc_next;
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] w_beats_next;
    logic             r_out_valid;
    logic             w_out_valid_next;
    logic [OUT_W-1:0] r_out_data;
    logic [OUT_W-1:0] w_out_data_next;
    logic [CNT_W-1:0] r_out_beats;
    logic [CNT_W-1:0] w_out_beats_next;

    logic [OUT_W-1:0] w_base;
    logic [OUT_W-1:0] w_sum;
    logic [CNT_W-1:0] w_beats_base;
    logic [CNT_W-1:0] w_beats_inc;

    // In IDLE the incoming tree value starts a fresh frame, so the running terms read as zero.
    assign w_base       = (r_state == DOT_ACCUM) ? r_acc : '0;
    assign w_beats_base = (r_state == DOT_ACCUM) ? r_beats : '0;
    assign w_beats_inc  = (&w_beats_base) ? w_beats_base : w_beats_base + CNT_W'(1);

`ifdef DOT_SATURATE_EN
    logic [OUT_W:0] w_sum_wide;
    assign w_sum_wide = {1'b0, w_base} + (OUT_W+1)'(w_tree_data);
    // Once clamped the accumulator sits at all-ones, so every later add re-clamps.
    assign w_sum      = w_sum_wide[OUT_W] ? '1 : w_sum_wide[OUT_W-1:0];
`else
    assign w_sum      = w_base + OUT_W'(w_tree_data);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_beats_next     = r_beats;
        w_out_valid_next = 1'b0;
        w_out_data_next  = r_out_data;
        w_out_beats_next = r_out_beats;
        if (w_tree_valid) begin
            if (w_tree_last) begin
                w_state_next     = DOT_IDLE;
                w_out_valid_next = 1'b1;
                w_out_data_next  = w_sum;
                w_out_beats_next = w_beats_inc;
            end else begin
                w_state_next = DOT_ACCUM;
                w_acc_next   = w_sum;
                w_beats_next = w_beats_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= DOT_IDLE;
            r_acc       <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_beats     <= w_beats_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_out_beats <= w_out_beats_next;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_beats = r_out_beats;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_dot_product.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_dot_product
// Brief    : Scoreboard bench for pipelined_dot_product across three configs
//            (N=4/OUT_W=32, N=4/OUT_W=20, N=1/W=3); honours DOT_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_dot_product;

    typedef struct {
        longint data;
        longint beats;
        longint cyc;
    } exp_t;

    localparam int LAT4 = 4;
    localparam int LAT1 = 2;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   rst_q = 1'b0;
    longint cyc   = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    exp_t   sb0[$];
    exp_t   sb1[$];
    exp_t   sb2[$];
    longint part_sum   [3];
    int     part_beats [3];
    longint hold_d     [3];
    longint hold_b     [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    pipelined_dot_product_if #(.N(4), .W(8), .OUT_W(32), .CNT_W(8)) bus0 ();
    pipelined_dot_product_if #(.N(4), .W(8), .OUT_W(20), .CNT_W(8)) bus1 ();
    pipelined_dot_product_if #(.N(1), .W(3), .OUT_W(8),  .CNT_W(4)) bus2 ();

    pipelined_dot_product #(.N(4), .W(8), .OUT_W(32), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pipelined_dot_product #(.N(4), .W(8), .OUT_W(20), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipelined_dot_product #(.N(1), .W(3), .OUT_W(8),  .CNT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clip_sum(input longint s, input int ow);
        longint mx;
        mx = (longint'(1) << ow) - 1;
`ifdef DOT_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s % (mx + 1);
`endif
    endfunction

    function automatic longint clip_beats(input int b, input int cw);
        longint mx;
        mx = (longint'(1) << cw) - 1;
        return (longint'(b) > mx) ? mx : longint'(b);
    endfunction

    function automatic int sb_size(input int inst);
        case (inst)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int inst);
        case (inst)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Reference: frame result is the plain sum of every element product, then wrapped or clamped.
    task automatic model_beat(input int inst, input longint prod, input logic last);
        exp_t e;
        part_sum[inst]   += prod;
        part_beats[inst] += 1;
        if (last) begin
            case (inst)
                0: begin
                    e.data = clip_sum(part_sum[0], 32); e.beats = clip_beats(part_beats[0], 8);
                    e.cyc = cyc + LAT4; sb0.push_back(e);
                end
                1: begin
                    e.data = clip_sum(part_sum[1], 20); e.beats = clip_beats(part_beats[1], 8);
                    e.cyc = cyc + LAT4; sb1.push_back(e);
                end
                default: begin
                    e.data = clip_sum(part_sum[2], 8); e.beats = clip_beats(part_beats[2], 4);
                    e.cyc = cyc + LAT1; sb2.push_back(e);
                end
            endcase
            part_sum[inst]   = 0;
            part_beats[inst] = 0;
        end
    endtask

    task automatic idle_all();
        bus0.in_valid = 1'b0; bus0.in_last = 1'($urandom_range(1));
        bus0.a_vec = $urandom; bus0.b_vec = $urandom;
        bus1.in_valid = 1'b0; bus1.in_last = 1'($urandom_range(1));
        bus1.a_vec = $urandom; bus1.b_vec = $urandom;
        bus2.in_valid = 1'b0; bus2.in_last = 1'($urandom_range(1));
        bus2.a_vec = 3'($urandom); bus2.b_vec = 3'($urandom);
    endtask

    task automatic cycle();
        @(negedge clk);
        idle_all();
    endtask

    task automatic drive0(input logic last, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = 0;
        bus0.in_valid = 1'b1; bus0.in_last = last; bus0.a_vec = a; bus0.b_vec = b;
        for (int i = 0; i < 4; i++) p += longint'(a[i*8 +: 8]) * longint'(b[i*8 +: 8]);
        model_beat(0, p, last);
    endtask

    task automatic drive1(input logic last, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = 0;
        bus1.in_valid = 1'b1; bus1.in_last = last; bus1.a_vec = a; bus1.b_vec = b;
        for (int i = 0; i < 4; i++) p += longint'(a[i*8 +: 8]) * longint'(b[i*8 +: 8]);
        model_beat(1, p, last);
    endtask

    task automatic drive2(input logic last, input logic [2:0] a, input logic [2:0] b);
        bus2.in_valid = 1'b1; bus2.in_last = last; bus2.a_vec = a; bus2.b_vec = b;
        model_beat(2, longint'(a) * longint'(b), last);
    endtask

    task automatic mon(input int inst, input logic ov, input logic [63:0] od, input logic [63:0] ob);
        exp_t  e;
        string nm;
        nm = $sformatf("i%0d", inst);
        if (!rst_q) begin
            chk({nm, "_rst_valid"}, 64'(ov), 64'd0);
            chk({nm, "_rst_data"}, od, 64'd0);
            chk({nm, "_rst_beats"}, ob, 64'd0);
            while (sb_size(inst) != 0) e = sb_pop(inst);
            hold_d[inst] = 0;
            hold_b[inst] = 0;
        end else if (ov) begin
            if (sb_size(inst) == 0) begin
                chk({nm, "_spurious_pulse"}, 64'(ov), 64'd0);
            end else begin
                e = sb_pop(inst);
                chk({nm, "_data"}, od, 64'(e.data));
                chk({nm, "_beats"}, ob, 64'(e.beats));
                chk({nm, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
            hold_d[inst] = longint'(od);
            hold_b[inst] = longint'(ob);
        end else begin
            chk({nm, "_hold_data"}, od, 64'(hold_d[inst]));
            chk({nm, "_hold_beats"}, ob, 64'(hold_b[inst]));
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.out_valid, 64'(bus0.out_data), 64'(bus0.out_beats));
        mon(1, bus1.out_valid, 64'(bus1.out_data), 64'(bus1.out_beats));
        mon(2, bus2.out_valid, 64'(bus2.out_data), 64'(bus2.out_beats));
    end

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((sb_size(0) + sb_size(1) + sb_size(2)) != 0 && guard < 64) begin
            cycle();
            guard++;
        end
        chk({tag, "_pending_i0"}, 64'(sb_size(0)), 64'd0);
        chk({tag, "_pending_i1"}, 64'(sb_size(1)), 64'd0);
        chk({tag, "_pending_i2"}, 64'(sb_size(2)), 64'd0);
        repeat (3) cycle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            part_sum[i] = 0; part_beats[i] = 0; hold_d[i] = 0; hold_b[i] = 0;
        end
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single-beat frame (70) alongside the N=1 case (49).
        cycle(); drive0(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8)); drive2(1'b1, 3'd7, 3'd7);
        cycle();

        // Three beats with a bubble between beats 2 and 3 -> 210.
        cycle(); drive0(1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        cycle(); drive0(1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        cycle();
        cycle(); drive0(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));

        for (int k = 1; k <= 10; k++) begin
            cycle(); drive0(1'b1, pack4(k, 0, 0, 0), pack4(1, 0, 0, 0));
        end

        // OUT_W=20 overflow: five beats of 260100; N=1 frame overflowing both sum and beat count.
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (j < 5) drive1(j == 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            drive2(j == 19, 3'd7, 3'd7);
        end
        drain("directed");

        // Reset after beat 2 of a 4-beat frame discards it.
        cycle(); drive0(1'b0, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
        cycle(); drive0(1'b0, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
        cycle(); rst_n = 1'b0;
        part_sum[0] = 0; part_beats[0] = 0;
        cycle(); rst_n = 1'b1;
        cycle(); drive0(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        drain("after_reset");

        repeat (400) begin
            cycle();
            if ($urandom_range(3) != 0) drive0($urandom_range(2) == 0, $urandom, $urandom);
            if ($urandom_range(3) != 0) drive1($urandom_range(2) == 0, $urandom, $urandom);
            if ($urandom_range(3) != 0) drive2($urandom_range(3) == 0, 3'($urandom), 3'($urandom));
        end
        cycle();
        drive0(1'b1, $urandom, $urandom);
        drive1(1'b1, $urandom, $urandom);
        drive2(1'b1, 3'($urandom), 3'($urandom));
        drain("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_dot_product.md
# pipelined_dot_product

Parametrised streaming inner-product engine: multiplies two N-element unsigned vectors element-wise, reduces the products through a registered adder tree, and accumulates successive beats into one result per frame (delimited by `in_last`). It is the general successor to the fixed 3×3-bit inner product in the arithmetic datapath. It accepts one beat per cycle with no backpressure and emits one registered result per frame.

## Interface
- `N`, 4: vector element count, N ≥ 1.
- `W`, 8: element width in bits, unsigned.
- `OUT_W`, 32: result/accumulator width; must be ≥ 2W+CLOG2(N).
- `CNT_W`, 8: beat-counter width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  beat qualifier.
- `in_last`  in  1  final beat of frame; ignored when `in_valid`=0.
- `a_vec`  in  N*W  element i at bits [i*W +: W].
- `b_vec`  in  N*W  same packing as `a_vec`.
- `out_valid`  out  1  one-cycle pulse, one per frame.
- `out_data`  out  OUT_W  frame sum; holds until next pulse.
- `out_beats`  out  CNT_W  beats in frame, saturating at 2^CNT_W−1.

## Operation
- Stage 1: N products `a[i]*b[i]` (2W bits each), registered with valid/last.
- Stages 2..CLOG2(N)+1: binary adder tree, one registered level per stage; odd leftovers pass through a register. Level k width = 2W+k. N=1: no tree levels.
- Final stage: accumulator FSM, states IDLE (no partial sum) and ACCUM (partial sum held).
  - IDLE, tree valid, last=0 → acc=tree, beats=1, go ACCUM.
  - IDLE, tree valid, last=1 → emit tree, beats=1, stay IDLE.
  - ACCUM, tree valid, last=0 → acc+=tree, beats+=1 (saturating).
  - ACCUM, tree valid, last=1 → emit acc+tree, beats+1, go IDLE.
  - Tree not valid → hold state and acc (bubbles allowed mid-frame).
- Arithmetic unsigned; accumulator OUT_W bits; overflow per Configuration.
- Reset: state IDLE, acc 0, all pipeline valid bits 0, `out_valid`=0, `out_data`=0, `out_beats`=0. Data registers other than valid may stay unreset.
- Reset mid-frame discards all in-flight beats and the partial sum; no output is produced for that frame.

## Timing
- LAT = CLOG2(N)+2. `out_valid` is high in the cycle after edge k+LAT−1, where edge k samples the last beat. N=4 gives LAT=4; N=1 gives LAT=2.
- Full throughput: a new beat is accepted every cycle. Single-beat frames back-to-back produce one result per cycle.
- `out_valid` is never high for two cycles from one frame. `out_data` and `out_beats` change only on the edge that raises `out_valid`.
- `rst_n` sampled low at an edge takes effect on that edge; no output appears until LAT edges after the first post-reset beat.

## Configuration
- `DOT_SATURATE_EN` defined: accumulator and emitted sum clamp at 2^OUT_W−1. The clamp is sticky for the rest of the frame and clears at frame end.
- Not defined: the sum wraps modulo 2^OUT_W. The carry is discarded and no flag is raised.

## Structure
- `dot_pkg`: `clog2` constant function, FSM state enum (`DOT_IDLE`, `DOT_ACCUM`), localparams for tree depth and level widths.
- One sub-module, `dot_adder_tree`. It is parametrised by leaf count and leaf width, carries valid/last, and adds CLOG2(N) cycles of latency.
- Multiplier stage and accumulator FSM live in the top module.

## Test plan
- N=4, W=8. Single-beat frame a=[1,2,3,4], b=[5,6,7,8], last=1 → `out_valid` 4 edges later, out_data=70, out_beats=1.
- Three-beat frame of the same vectors, with one idle cycle between beats 2 and 3 → single pulse with out_data=210, out_beats=3.
- Ten consecutive single-beat frames, a=[k,0,0,0], b=[1,0,0,0] for k=1..10 → ten consecutive pulses with out_data=1..10.
- OUT_W=20. Five-beat frame with all elements 255 (260100 per beat) → 1048575 with `DOT_SATURATE_EN`, 251924 without.
- `rst_n` low for one edge after beat 2 of a 4-beat frame → no pulse for that frame. A following single-beat frame with result 70 → out_data=70, out_beats=1.
- N=1, W=3, a=7, b=7, last=1 → out_data=49 two edges later.
